// File: rtl/dpa_mask_feeder_if.sv
// Operand/share handshake bundle for the DPA masking front end.
// The slave side is the feeder; the master side is the producer/consumer around it.
interface dpa_mask_feeder_if #(
  parameter int unsigned NUMBER_OF_SHARES = 3,
  parameter int unsigned WIDTH            = 8
);
  localparam int unsigned R    = NUMBER_OF_SHARES * (NUMBER_OF_SHARES - 1) / 2;
  localparam int unsigned SH_W = NUMBER_OF_SHARES * WIDTH;
  localparam int unsigned RO_W = WIDTH * R;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [SH_W-1:0]   x_sh;
  logic [SH_W-1:0]   y_sh;
  logic [RO_W-1:0]   r_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, x_sh, y_sh, r_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, x_sh, y_sh, r_out
  );
endinterface

// File: rtl/dpa_mask_feeder.sv
// Splits operands a/b into Boolean shares and supplies fresh multiplier randomness,
// drawing every operation from a freshly filled LFSR pool.
module dpa_mask_feeder #(
  parameter int unsigned NUMBER_OF_SHARES = 3,
  parameter int unsigned WIDTH            = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [63:0]        seed,
  input  logic               seed_load,
  output logic               busy,
  dpa_mask_feeder_if.slave   bus
);
  localparam int unsigned N         = NUMBER_OF_SHARES;
  localparam int unsigned W         = WIDTH;
  localparam int unsigned R         = N * (N - 1) / 2;
  localparam int unsigned RAND_BITS = 2 * (N - 1) * W + W * R;
  localparam int unsigned F         = (RAND_BITS + 15) / 16;
  localparam int unsigned CNT_W     = (F > 1) ? $clog2(F) : 1;
  localparam int unsigned SH_W      = N * W;
  localparam int unsigned RO_W      = W * R;
  localparam logic [63:0] LFSR_RST  = 64'hACE1_0000_0000_0001;

  typedef enum logic [1:0] {S_FILL, S_READY, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [63:0]            lfsr_q, lfsr_d;
  logic [RAND_BITS-1:0]   pool_q, pool_d;
  logic [SH_W-1:0]        x_q, x_d;
  logic [SH_W-1:0]        y_q, y_d;
  logic [RO_W-1:0]        r_q, r_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [63:0]            lfsr_step;
  logic [RAND_BITS-1:0]   fill_mask;
  logic [RAND_BITS-1:0]   fill_data;
  logic [SH_W-1:0]        x_new, y_new;
  logic [RO_W-1:0]        r_new;
  logic [W-1:0]           x_acc, y_acc;

  // Sixteen LFSR steps per fill cycle; the low 16 bits are the fresh word.
  always_comb begin
    lfsr_step = lfsr_q;
    for (int i = 0; i < 16; i++) begin
      lfsr_step = {lfsr_step[62:0],
                   lfsr_step[63] ^ lfsr_step[62] ^ lfsr_step[60] ^ lfsr_step[59]};
    end
    fill_mask = RAND_BITS'(16'hFFFF) << {cnt_q, 4'b0000};
    fill_data = RAND_BITS'(lfsr_step[15:0]) << {cnt_q, 4'b0000};
  end

  // Share mapping from the completed pool; share 0 absorbs the plaintext.
  always_comb begin
    x_new = '0;
    y_new = '0;
    x_acc = '0;
    y_acc = '0;
    for (int unsigned s = 1; s < N; s++) begin
      x_new[s*W +: W] = pool_q[(s-1)*W +: W];
      y_new[s*W +: W] = pool_q[(N-1+s-1)*W +: W];
      x_acc = x_acc ^ pool_q[(s-1)*W +: W];
      y_acc = y_acc ^ pool_q[(N-1+s-1)*W +: W];
    end
    x_new[W-1:0] = bus.a ^ x_acc;
    y_new[W-1:0] = bus.b ^ y_acc;
    r_new = pool_q[2*(N-1)*W +: RO_W];
  end

  // Next-state and registered-output logic; seed_load overrides the handshakes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    pool_d  = pool_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    if (seed_load) begin
      lfsr_d  = (seed == 64'h0) ? 64'h1 : seed;
      state_d = S_FILL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          lfsr_d = lfsr_step;
          pool_d = (pool_q & ~fill_mask) | fill_data;
          if (cnt_q == CNT_W'(F - 1)) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (bus.in_valid) begin
            x_d     = x_new;
            y_d     = y_new;
            r_d     = r_new;
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      endcase
    end
    in_ready_d  = (state_d == S_READY);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d == S_FILL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_RST;
      pool_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      pool_q      <= pool_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_sh      = x_q;
  assign bus.y_sh      = y_q;
  assign bus.r_out     = r_q;
  assign busy          = busy_q;

endmodule

// File: doc/dpa_mask_feeder.md
# dpa_mask_feeder

Front-end masking stage for the DPA-protected ALU datapath. It takes plaintext operands `a` and `b` and splits each into `NUMBER_OF_SHARES` Boolean shares using an internal LFSR. It also supplies the fresh per-bit randomness `r` that the downstream DOM/TI share multiplier array consumes. Randomness is gathered into a pool over several cycles and used exactly once per operation. Input and output use valid/ready handshakes.

## Interface
Parameters:
- `NUMBER_OF_SHARES`, 3, number of shares per operand; must be ≥ 2.
- `WIDTH`, 8, operand width in bits.
- Derived `R = NUMBER_OF_SHARES*(NUMBER_OF_SHARES-1)/2`: random bits per multiplier bit.
- Derived `RAND_BITS = 2*(NUMBER_OF_SHARES-1)*WIDTH + WIDTH*R`.
- Derived `F = ceil(RAND_BITS/16)`: number of fill cycles.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `seed` in 64: LFSR seed value.
- `seed_load` in 1: when high, loads `seed` into the LFSR.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `a` in WIDTH, `b` in WIDTH: plaintext operands.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `x_sh` out NUMBER_OF_SHARES*WIDTH: shares of `a`; share s is at `[s*WIDTH +: WIDTH]`.
- `y_sh` out NUMBER_OF_SHARES*WIDTH: shares of `b`, same layout.
- `r_out` out WIDTH*R: fresh randomness; the R bits for operand bit i are at `[i*R +: R]`.
- `busy` out 1: high in FILL state.

## Operation

LFSR:
- 64-bit Fibonacci LFSR.
- One step: `fb = s[63]^s[62]^s[60]^s[59]`, then `s <= {s[62:0], fb}`.
- In FILL, the LFSR advances 16 steps per clock. The 16 new bits (`s_new[15:0]`) are that cycle's output word.
- The LFSR is frozen in READY and OUT.

Pool:
- `RAND_BITS` register.
- On fill cycle k (k = 0..F-1), the output word is written to `pool[16*k +: 16]`.
- Bits at or above `RAND_BITS` are discarded.

FSM states:
- FILL: counter runs 0..F-1. After the cycle with counter = F-1, go to READY.
- READY: `in_ready=1`. On `in_valid`, register the outputs and go to OUT.
- OUT: `out_valid=1`. On `out_ready`, clear the counter and go to FILL.

Share mapping, applied at acceptance (s = 1..NUMBER_OF_SHARES-1):
- `x_sh[s] = pool[(s-1)*WIDTH +: WIDTH]`.
- `y_sh[s] = pool[(NUMBER_OF_SHARES-1+s-1)*WIDTH +: WIDTH]`.
- `x_sh[0] = a ^ XOR of x_sh[1..]`.
- `y_sh[0] = b ^ XOR of y_sh[1..]`.
- `r_out = pool[2*(NUMBER_OF_SHARES-1)*WIDTH +: WIDTH*R]`.

Invariants:
- Each pool is used for exactly one accepted operation.
- Share 0 is never computed from an unregistered or reused pool.

Seed load:
- `seed_load` has priority over every handshake; `reset` has priority over `seed_load`.
- The LFSR takes `seed`; a zero seed loads `64'h1` instead.
- The FSM goes to FILL with counter 0.
- `out_valid` drops and any pending output is discarded.
- The LFSR does not also step in the seed-load cycle.

Reset values:
- LFSR = `64'hACE1_0000_0000_0001`.
- State FILL, counter 0, pool 0.
- `out_valid=0`, `in_ready=0`, `busy=1`.
- `x_sh`, `y_sh`, `r_out` = 0.

## Timing
- After `reset` deasserts, FILL takes F cycles; `in_ready` rises on cycle F+1. For N=3, W=8: F=4.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only.
- There is no combinational path from `in_valid` or `out_ready` to any output.
- Acceptance to `out_valid`: 1 cycle.
- With `out_ready` tied high, one operation completes every F+2 cycles.
- While `out_valid && !out_ready`, all outputs stay stable and the LFSR is frozen.
- `in_valid` in FILL or OUT is ignored; there is no acceptance.
- `reset` mid-FILL or mid-OUT returns to the reset values on the next edge. Any pending output is lost.
- `seed_load` in the same cycle as an acceptance: the seed load wins and the operand is not accepted.

## Test plan
- Reset, then `seed=64'h1` with `seed_load` pulse -> `busy=1` for 4 cycles, then `in_ready=1`. Feed `a=8'hA5`, `b=8'h3C` -> next cycle `out_valid=1`, XOR of the `x_sh` shares = `8'hA5`, XOR of the `y_sh` shares = `8'h3C`, and `r_out` equals pool bits [32..55].
- Backpressure: hold `out_ready=0` for 10 cycles -> outputs and LFSR unchanged. Release -> FILL restarts with counter 0.
- Seed 0 -> behaviour identical to seed `64'h1` (same shares for the same operands).
- Determinism: same seed, same sequence of operands `8'h00`, `8'hFF`, `8'h5A` run twice -> identical `x_sh`, `y_sh`, `r_out` streams. Two consecutive operations never repeat a pool.
- Reset asserted in OUT with `out_valid=1` -> next cycle `out_valid=0`, outputs 0, LFSR = `64'hACE1_0000_0000_0001`.
- End-to-end: feed `x_sh`, `y_sh`, `r_out` per bit into the share multiplier array -> XOR of the product shares one cycle later = `a & b` (`8'h24` for A5/3C) over 1000 random operand pairs.
